event_pending_unit: RTL
=======================

EVENT_PENDING_UNIT -- requirements
Module: event_pending_unit

Interface
REQ-001 The module SHALL have parameter EventCount, default 8, giving the number of event sources; legal range is 2..32.
REQ-002 The module SHALL have derived localparam IdxWidth, equal to $clog2(EventCount), giving the index width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port event_in, input, EventCount bits: single-cycle event pulses, one per source.
REQ-006 The module SHALL have port mask_in, input, EventCount bits: per-source enable; 1 means the source is eligible for offer.
REQ-007 The module SHALL have port clear_all_in, input, 1 bit: synchronous flush of all pending and overflow state.
REQ-008 The module SHALL have port pending_out, output, EventCount bits: the registered sticky pending vector (unmasked).
REQ-009 The module SHALL have port any_pending_out, output, 1 bit: OR of (pending & mask_in), for the downstream OR bit reducer.
REQ-010 The module SHALL have port overflow_out, output, EventCount bits: sticky flags, set when an event is lost to an already-pending source.
REQ-011 The module SHALL have port req_valid_out, output, 1 bit: an offer of one pending source to the consumer.
REQ-012 The module SHALL have port req_idx_out, output, IdxWidth bits: the offered source index.
REQ-013 The module SHALL have port req_ready_in, input, 1 bit: the consumer accepts the offer.

Function
REQ-014 event_in[i]=1 at a rising edge SHALL set pending[i], which is visible in the following cycle.
REQ-015 any_pending_out SHALL be combinational from the pending register and mask_in, with no added register stage.
REQ-016 The FSM SHALL have exactly two states: IDLE and OFFER.
REQ-017 In IDLE, when (pending & mask_in) != 0, the FSM SHALL at the next edge register the lowest set index into req_idx_out and enter OFFER.
REQ-018 In OFFER, req_valid_out SHALL be 1; in IDLE, req_valid_out SHALL be 0.
REQ-019 req_idx_out SHALL be held stable while req_valid_out=1 and req_ready_in=0, regardless of mask_in or event_in changes; an offer is never withdrawn except by clear_all_in.
REQ-020 A handshake (req_valid_out=1 and req_ready_in=1 at an edge) SHALL clear pending[req_idx_out] and return the FSM to IDLE.
REQ-021 After a handshake, req_valid_out SHALL be 0 for at least one cycle, giving a maximum throughput of one accept per 2 cycles.
REQ-022 Event-to-offer latency SHALL be 2 edges: event_in sampled at edge k gives req_valid_out=1 after edge k+1, provided the FSM is IDLE, the source is masked-in and it is the lowest pending index.
REQ-023 When event_in[i] coincides with a handshake on index i, the set SHALL win: pending[i] stays 1 and overflow[i] is not set.
REQ-024 When event_in[i] arrives while pending[i]=1 and no handshake on i occurs that edge, overflow[i] SHALL be set.
REQ-025 overflow bits SHALL be cleared only by clear_all_in or reset.
REQ-026 When clear_all_in=1 at an edge, pending and overflow SHALL become 0, the FSM SHALL go to IDLE, and req_valid_out SHALL be 0 after that edge.
REQ-027 clear_all_in SHALL win over simultaneous event_in and over a simultaneous handshake.
REQ-028 Masking a pending source SHALL retain its pending bit and only exclude it from any_pending_out and from selection.
REQ-029 Sources with index >= EventCount SHALL be impossible by construction, so req_idx_out is always < EventCount.

Reset
REQ-030 While rst_n=0, independent of clk, the outputs SHALL be: pending_out=0, overflow_out=0, req_valid_out=0, req_idx_out=0, FSM=IDLE.
REQ-031 Following reset, any_pending_out SHALL be 0.
REQ-032 Reset assertion mid-offer SHALL drop req_valid_out immediately, without waiting for a clock edge.
REQ-033 On deassertion of rst_n, the first active edge SHALL sample inputs normally.

Verification (EventCount=8)
REQ-034 Scenario: mask=0xFF, event_in=0x28 for one cycle, ready=1 -> offers idx 3 and then idx 5, each valid for 1 cycle, with 1 idle cycle between; pending returns to 0x00.
REQ-035 Scenario: ready=0, offer idx 2 pending, then mask changes to 0x00 and event_in=0x01 -> req_idx_out stays 2 and valid stays 1; pending=0x05; overflow=0x00.
REQ-036 Scenario: pending[4]=1, then event_in=0x10 again without a handshake -> overflow_out=0x10 and pending_out=0x10.
REQ-037 Scenario: event_in=0x10 on the same edge as a handshake on idx 4 -> pending_out=0x10, overflow_out=0x00, and idx 4 is re-offered after 1 idle cycle.
REQ-038 Scenario: clear_all_in=1 together with event_in=0xFF during an offer -> pending=0x00, overflow=0x00, req_valid_out=0 next cycle.
REQ-039 Scenario: rst_n pulsed low between clock edges during an offer -> req_valid_out=0 and all vectors=0 asynchronously.

Source files
------------

// File: rtl/event_pending_unit.sv
// event_pending_unit: sticky per-source pending/overflow tracking with a
// lowest-index-first valid/ready offer to a single consumer.
module event_pending_unit #(
    parameter int EventCount = 8,
    localparam int IdxWidth = $clog2(EventCount)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [EventCount-1:0] event_in,
    input  logic [EventCount-1:0] mask_in,
    input  logic                  clear_all_in,
    output logic [EventCount-1:0] pending_out,
    output logic                  any_pending_out,
    output logic [EventCount-1:0] overflow_out,
    output logic                  req_valid_out,
    output logic [IdxWidth-1:0]   req_idx_out,
    input  logic                  req_ready_in
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;
    logic [0:0]            state_q, state_d;
    logic [EventCount-1:0] pending_q, pending_d, overflow_q, overflow_d, ack_vec, eligible;
    logic [IdxWidth-1:0]   idx_q, idx_d, sel_idx;
    logic                  hs;
    assign eligible        = pending_q & mask_in;
    assign any_pending_out = |eligible;
    assign hs              = (state_q == OFFER) && req_ready_in;
    assign ack_vec         = hs ? (EventCount'(1) << idx_q) : '0;
    // Scan downward so the last hit is the lowest eligible index.
    always_comb begin
        sel_idx = '0;
        for (int i = EventCount - 1; i >= 0; i--)
            if (eligible[i]) sel_idx = IdxWidth'(i);
    end
    // A new event on the source being acknowledged re-arms it without overflow.
    always_comb begin
        pending_d  = clear_all_in ? '0 : (pending_q & ~ack_vec) | event_in;
        overflow_d = clear_all_in ? '0 : overflow_q | (event_in & pending_q & ~ack_vec);
        state_d    = clear_all_in ? IDLE :
                     (state_q == IDLE) ? (any_pending_out ? OFFER : IDLE) :
                     (req_ready_in ? IDLE : OFFER);
        idx_d      = (!clear_all_in && state_q == IDLE && any_pending_out) ? sel_idx : idx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            idx_q      <= idx_d;
        end
    end
    assign pending_out   = pending_q;
    assign overflow_out  = overflow_q;
    assign req_valid_out = (state_q == OFFER);
    assign req_idx_out   = idx_q;
endmodule
